// File: rtl/qpsk_demod_if.sv
// Sample-in / decision-out bus of the QPSK hard-decision demodulator.
// QPSK_DEMOD_STATS_EN adds the symbol and sync-slip counter outputs.
interface qpsk_demod_if #(
    parameter int unsigned DATA_W = 12
);
    logic signed [DATA_W-1:0] i_I;
    logic signed [DATA_W-1:0] i_Q;
    logic                     i_sync;
    logic                     i_valid;
    logic                     o_ready;
    logic                     o_I;
    logic                     o_Q;
    logic                     o_valid;
    logic                     i_ready;
`ifdef QPSK_DEMOD_STATS_EN
    logic [15:0]              o_sym_cnt;
    logic [15:0]              o_sync_slip;

    modport slave (
        input  i_I, i_Q, i_sync, i_valid, i_ready,
        output o_ready, o_I, o_Q, o_valid, o_sym_cnt, o_sync_slip
    );
    modport master (
        output i_I, i_Q, i_sync, i_valid, i_ready,
        input  o_ready, o_I, o_Q, o_valid, o_sym_cnt, o_sync_slip
    );
`else
    modport slave (
        input  i_I, i_Q, i_sync, i_valid, i_ready,
        output o_ready, o_I, o_Q, o_valid
    );
    modport master (
        output i_I, i_Q, i_sync, i_valid, i_ready,
        input  o_ready, o_I, o_Q, o_valid
    );
`endif
endinterface

// File: rtl/qpsk_demod.sv
// Integrate-and-dump QPSK hard-decision demodulator: SPS samples per symbol, sign slicer.
// Optional QPSK_DEMOD_STATS_EN: delivered-symbol counter and sync-slip counter.
module qpsk_demod #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned SPS    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    qpsk_demod_if.slave  bus
);
    localparam int unsigned ACC_W = DATA_W + $clog2(SPS) + 1;
    localparam int unsigned EXT_W = ACC_W - DATA_W;
    localparam int unsigned CNT_W = (SPS > 1) ? $clog2(SPS) : 1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic                    o_i_q, o_i_d;
    logic                    o_q_q, o_q_d;
    logic                    o_valid_q, o_valid_d;

    logic                    ready_c;
    logic                    accept_c;
    logic                    out_xfer_c;
    logic                    last_c;
    logic signed [ACC_W-1:0] sum_i_c;
    logic signed [ACC_W-1:0] sum_q_c;

    assign ready_c    = !o_valid_q || bus.i_ready;
    assign accept_c   = bus.i_valid && ready_c;
    assign out_xfer_c = o_valid_q && bus.i_ready;

    // A sync sample restarts the symbol, so it only closes one when a symbol is a single sample.
    assign last_c = (SPS == 1) || (!bus.i_sync && (cnt_q == CNT_W'(SPS - 1)));

    assign sum_i_c = (bus.i_sync ? ACC_W'(0) : acc_i_q) + {{EXT_W{bus.i_I[DATA_W-1]}}, bus.i_I};
    assign sum_q_c = (bus.i_sync ? ACC_W'(0) : acc_q_q) + {{EXT_W{bus.i_Q[DATA_W-1]}}, bus.i_Q};

    always_comb begin
        cnt_d     = cnt_q;
        acc_i_d   = acc_i_q;
        acc_q_d   = acc_q_q;
        o_i_d     = o_i_q;
        o_q_d     = o_q_q;
        o_valid_d = o_valid_q;

        if (out_xfer_c) begin
            o_valid_d = 1'b0;
        end

        if (accept_c) begin
            if (last_c) begin
                // Positive sum slices to 1; zero and negative slice to 0.
                o_i_d     = !sum_i_c[ACC_W-1] && (sum_i_c != ACC_W'(0));
                o_q_d     = !sum_q_c[ACC_W-1] && (sum_q_c != ACC_W'(0));
                o_valid_d = 1'b1;
                acc_i_d   = ACC_W'(0);
                acc_q_d   = ACC_W'(0);
                cnt_d     = CNT_W'(0);
            end else begin
                acc_i_d   = sum_i_c;
                acc_q_d   = sum_q_c;
                cnt_d     = bus.i_sync ? CNT_W'(1) : CNT_W'(cnt_q + CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= CNT_W'(0);
            acc_i_q   <= ACC_W'(0);
            acc_q_q   <= ACC_W'(0);
            o_i_q     <= 1'b0;
            o_q_q     <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            o_i_q     <= o_i_d;
            o_q_q     <= o_q_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign bus.o_ready = ready_c;
    assign bus.o_I     = o_i_q;
    assign bus.o_Q     = o_q_q;
    assign bus.o_valid = o_valid_q;

`ifdef QPSK_DEMOD_STATS_EN
    logic [15:0] sym_cnt_q, sym_cnt_d;
    logic [15:0] sync_slip_q, sync_slip_d;

    // Symbol count wraps; slip count saturates.
    always_comb begin
        sym_cnt_d   = sym_cnt_q;
        sync_slip_d = sync_slip_q;
        if (out_xfer_c) begin
            sym_cnt_d = 16'(sym_cnt_q + 16'd1);
        end
        if (accept_c && bus.i_sync && (cnt_q != CNT_W'(0)) && (sync_slip_q != 16'hFFFF)) begin
            sync_slip_d = 16'(sync_slip_q + 16'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_q   <= 16'd0;
            sync_slip_q <= 16'd0;
        end else begin
            sym_cnt_q   <= sym_cnt_d;
            sync_slip_q <= sync_slip_d;
        end
    end

    assign bus.o_sym_cnt   = sym_cnt_q;
    assign bus.o_sync_slip = sync_slip_q;
`endif
endmodule

// File: tb/tb_qpsk_demod.sv
// Directed bench for qpsk_demod: symbol-sum model with a per-cycle compare process.
module tb_qpsk_demod;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned SPS    = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    qpsk_demod_if #(.DATA_W(DATA_W)) bus ();

    qpsk_demod #(.DATA_W(DATA_W), .SPS(SPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: partial symbol sums and decisions awaiting delivery.
    int pi_sum, pq_sum, p_n;
    bit exp_i[$];
    bit exp_q[$];
    bit del_i[$];
    bit del_q[$];
    int n_produced;
    int n_delivered;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pi_sum = 0; pq_sum = 0; p_n = 0;
        exp_i.delete();
        exp_q.delete();
    endtask

    task automatic model_accept(input int si, input int sq, input bit sync);
        if (sync) begin
            pi_sum = 0; pq_sum = 0; p_n = 0;
        end
        pi_sum += si;
        pq_sum += sq;
        p_n++;
        if (p_n == SPS) begin
            exp_i.push_back(pi_sum > 0);
            exp_q.push_back(pq_sum > 0);
            n_produced++;
            pi_sum = 0; pq_sum = 0; p_n = 0;
        end
    endtask

    // Offer one sample until the demod takes it, then feed the model.
    task automatic send(input int si, input int sq, input bit sync);
        int budget;
        budget = 200;
        @(negedge clk);
        bus.i_I     = DATA_W'(si);
        bus.i_Q     = DATA_W'(sq);
        bus.i_sync  = sync;
        bus.i_valid = 1'b1;
        #1;
        while (!bus.o_ready && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got o_ready=0 expected 1 within 200 cycles");
        end else begin
            model_accept(si, sq, sync);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_sync  = 1'b0;
    endtask

    task automatic send_sym(input int si, input int sq);
        for (int k = 0; k < int'(SPS); k++) send(si, sq, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: every handshake must deliver the next model decision; stalls hold data.
    bit prev_stall;
    bit prev_i, prev_q;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(bus.o_valid), 1);
                check("stall_I_stable", int'(bus.o_I), int'(prev_i));
                check("stall_Q_stable", int'(bus.o_Q), int'(prev_q));
            end
            if (bus.o_valid && bus.i_ready) begin
                if (exp_i.size() == 0) begin
                    check("unexpected_decision", 1, 0);
                end else begin
                    check("stream_I", int'(bus.o_I), int'(exp_i.pop_front()));
                    check("stream_Q", int'(bus.o_Q), int'(exp_q.pop_front()));
                end
                del_i.push_back(bus.o_I);
                del_q.push_back(bus.o_Q);
                n_delivered++;
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_i     = bus.o_I;
            prev_q     = bus.o_Q;
        end
    end

    initial begin
        logic [15:0] word;
        logic [15:0] got_word;
        int          base;
        int          amp;

        n_checks = 0; n_errors = 0; n_produced = 0; n_delivered = 0;
        prev_stall = 1'b0;
        model_reset();
        bus.i_I = '0; bus.i_Q = '0; bus.i_sync = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        #1;
        check("rst_o_valid", int'(bus.o_valid), 0);
        check("rst_o_I", int'(bus.o_I), 0);
        check("rst_o_Q", int'(bus.o_Q), 0);
        check("rst_o_ready", int'(bus.o_ready), 1);

        // Basic symbol: decision one cycle after the last sample.
        send_sym(100, -100);
        @(negedge clk);
        #1;
        check("t1_valid", int'(bus.o_valid), 1);
        check("t1_I", int'(bus.o_I), 1);
        check("t1_Q", int'(bus.o_Q), 0);
        idle(2);

        // Extremes and zero sums.
        send(2047, 1, 1'b0); send(2047, 1, 1'b0); send(-2048, 1, 1'b0); send(-2048, 1, 1'b0);
        @(negedge clk);
        #1;
        check("t3_neg2_I", int'(bus.o_I), 0);
        check("t3_pos4_Q", int'(bus.o_Q), 1);
        send(5, -1, 1'b0); send(-5, 0, 1'b0); send(3, 0, 1'b0); send(-3, 1, 1'b0);
        @(negedge clk);
        #1;
        check("t3_zero_I", int'(bus.o_I), 0);
        check("t3_zero_Q", int'(bus.o_Q), 0);
        idle(2);

        // Bit pairs LSB-first modulated as +/-amp, SPS copies each.
        word = 16'b1110100101111000;
        base = del_i.size();
        for (int k = 0; k < 8; k++) begin
            amp = 200 + 10 * k;
            send_sym(word[2*k] ? amp : -amp, word[2*k+1] ? amp : -amp);
        end
        idle(3);
        got_word = '0;
        check("t2_count", del_i.size() - base, 8);
        for (int k = 0; k < 8 && base + k < del_i.size(); k++) begin
            got_word[2*k]   = del_i[base + k];
            got_word[2*k+1] = del_q[base + k];
        end
        check("t2_word", int'(got_word), int'(16'hE978));

        // Backpressure: decision held, input stalled, then resumes.
        @(negedge clk);
        bus.i_ready = 1'b0;
        send_sym(400, 400);
        fork
            begin
                send_sym(-400, 400);
                send_sym(400, -400);
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    #1;
                    check("t4_o_ready", int'(bus.o_ready), 0);
                    check("t4_hold_I", int'(bus.o_I), 1);
                    check("t4_hold_Q", int'(bus.o_Q), 1);
                end
                @(negedge clk);
                bus.i_ready = 1'b1;
            end
        join
        idle(3);

        // Sync realign after two samples.
        base = del_i.size();
        send(-300, 300, 1'b0); send(-300, 300, 1'b0);
        send(50, -50, 1'b1); send(50, -50, 1'b0); send(50, -50, 1'b0); send(50, -50, 1'b0);
        @(negedge clk);
        #1;
        check("t5_valid", int'(bus.o_valid), 1);
        check("t5_I", int'(bus.o_I), 1);
        check("t5_Q", int'(bus.o_Q), 0);
`ifdef QPSK_DEMOD_STATS_EN
        check("t5_sync_slip", int'(bus.o_sync_slip), 1);
`endif
        idle(2);
        check("t5_single", del_i.size() - base, 1);

        // Reset with a decision pending clears o_valid at once.
        bus.i_ready = 1'b0;
        send_sym(100, 100);
        @(negedge clk);
        #1;
        check("t6_pending", int'(bus.o_valid), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_valid", int'(bus.o_valid), 0);
        check("t6_async_I", int'(bus.o_I), 0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        bus.i_ready = 1'b1;

        // Reset mid-symbol discards the partial sum.
        send(-2000, 2000, 1'b0); send(-2000, 2000, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        send_sym(10, -10);
        @(negedge clk);
        #1;
        check("t6_fresh_valid", int'(bus.o_valid), 1);
        check("t6_fresh_I", int'(bus.o_I), 1);
        check("t6_fresh_Q", int'(bus.o_Q), 0);
        idle(3);

        check("drain_empty", exp_i.size(), 0);
        check("model_pending", p_n, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
